// File: rtl/bias_relu_ser_pkg.sv
// bias_relu_ser_pkg: shared widths, FSM encoding and saturation bounds for
// the bias/ReLU serializer that follows the 16x6 matrix multiplier.
package bias_relu_ser_pkg;

    localparam int DW  = 24;
    localparam int NCH = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic signed [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [2:0]           LAST_IDX = 3'(NCH - 1);

endpackage

// File: rtl/bias_sat_relu_cxy.sv
// bias_sat_relu_cxy: single-channel bias add, saturation and optional ReLU.
// Build option: BIAS_RELU_SER_RELU_EN clamps negative results to zero.
module bias_sat_relu_cxy
    import bias_relu_ser_pkg::*;
(
    input  logic signed [DW-1:0] din,
    input  logic signed [DW-1:0] bias,
    output logic signed [DW-1:0] dout
);

    logic signed [DW:0]   sum;
    logic signed [DW-1:0] sat;

    // Clamp a one-bit-wider sum back into the DW-bit two's complement range.
    function automatic logic signed [DW-1:0] saturate(input logic signed [DW:0] s);
        if (s[DW] != s[DW-1]) begin
            return s[DW] ? SAT_MIN : SAT_MAX;
        end
        return s[DW-1:0];
    endfunction

    // Widened add cannot wrap; saturate, then optionally rectify.
    always_comb begin
        sum = {din[DW-1], din} + {bias[DW-1], bias};
        sat = saturate(sum);
`ifdef BIAS_RELU_SER_RELU_EN
        dout = sat[DW-1] ? '0 : sat;
`else
        dout = sat;
`endif
    end

endmodule

// File: rtl/bias_relu_serializer_cxy.sv
// bias_relu_serializer_cxy: captures 6-wide multiplier vectors, applies
// per-channel bias + saturation (+ ReLU when BIAS_RELU_SER_RELU_EN is defined),
// holds them in a two-slot buffer and streams one word per cycle out over
// valid/ready. A vector arriving with both slots occupied is dropped and
// flagged on the sticky OVF output.
module bias_relu_serializer_cxy
    import bias_relu_ser_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic signed [DW-1:0] IN1,
    input  logic signed [DW-1:0] IN2,
    input  logic signed [DW-1:0] IN3,
    input  logic signed [DW-1:0] IN4,
    input  logic signed [DW-1:0] IN5,
    input  logic signed [DW-1:0] IN6,
    input  logic                 B_WEN,
    input  logic                 B_REN,
    input  logic [2:0]           B_ADDR,
    input  logic [DW-1:0]        B_WDATA,
    output logic [DW-1:0]        B_RDATA,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic signed [DW-1:0] OUT_DATA,
    output logic [2:0]           OUT_IDX,
    output logic                 OUT_LAST,
    output logic                 OVF,
    input  logic                 OVF_CLR
);

    logic signed [DW-1:0] in_vec   [NCH];
    logic signed [DW-1:0] proc_vec [NCH];

    logic signed [DW-1:0] bias_q [NCH];
    logic signed [DW-1:0] bias_d [NCH];
    logic [DW-1:0]        b_rdata_q, b_rdata_d;

    logic signed [DW-1:0] buf_q [2][NCH];
    logic signed [DW-1:0] buf_d [2][NCH];

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [2:0] idx_q, idx_d;
    logic       last_q, last_d;
    logic       ovf_q, ovf_d;

    logic hs, last_hs, accept, drop;

    // Gather the six channel inputs into an indexable vector.
    always_comb begin
        in_vec[0] = IN1;
        in_vec[1] = IN2;
        in_vec[2] = IN3;
        in_vec[3] = IN4;
        in_vec[4] = IN5;
        in_vec[5] = IN6;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        bias_sat_relu_cxy u_ch (
            .din  (in_vec[k]),
            .bias (bias_q[k]),
            .dout (proc_vec[k])
        );
    end

    // Bias bank write and registered readback; unmapped addresses read as 0.
    always_comb begin
        bias_d = bias_q;
        if (B_WEN && (B_ADDR < 3'(NCH))) begin
            bias_d[B_ADDR] = B_WDATA;
        end
        b_rdata_d = b_rdata_q;
        if (B_REN) begin
            b_rdata_d = (B_ADDR < 3'(NCH)) ? bias_q[B_ADDR] : '0;
        end
    end

    // Buffer occupancy, pointers, word index, overflow flag and FSM next state.
    // A full buffer can still take a vector when its oldest slot frees this cycle.
    always_comb begin
        hs       = (state_q == SEND) && OUT_READY;
        last_hs  = hs && (idx_q == LAST_IDX);
        accept   = IN_VALID && ((cnt_q != 2'd2) || last_hs);
        drop     = IN_VALID && !accept;

        cnt_d    = cnt_q + {1'b0, accept} - {1'b0, last_hs};
        wr_ptr_d = accept  ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = last_hs ? ~rd_ptr_q : rd_ptr_q;

        idx_d = idx_q;
        if (hs) begin
            idx_d = last_hs ? 3'd0 : idx_q + 3'd1;
        end
        last_d = (idx_d == LAST_IDX);

        ovf_d = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);

        state_d = state_q;
        case (state_q)
            IDLE:    if (cnt_d != 2'd0) state_d = SEND;
            SEND:    if (last_hs && (cnt_d == 2'd0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        buf_d = buf_q;
        if (accept) begin
            buf_d[wr_ptr_q] = proc_vec;
        end
    end

    // Control and bias state; reset discards any buffered vectors.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            idx_q     <= 3'd0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
            b_rdata_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                bias_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            b_rdata_q <= b_rdata_d;
            bias_q    <= bias_d;
        end
    end

    // Vector storage is data only; validity is tracked by cnt_q.
    always_ff @(posedge CLK) begin
        buf_q <= buf_d;
    end

    assign OUT_VALID = (state_q == SEND);
    assign OUT_DATA  = OUT_VALID ? buf_q[rd_ptr_q][idx_q] : '0;
    assign OUT_IDX   = idx_q;
    assign OUT_LAST  = last_q;
    assign OVF       = ovf_q;
    assign B_RDATA   = b_rdata_q;

endmodule

// File: tb/tb_bias_relu_serializer_cxy.sv
// tb_bias_relu_serializer_cxy: self-checking bench for bias_relu_serializer_cxy.
// Expected words come from a queue-of-words model computed with plain integer
// arithmetic (add, clamp, optional rectify under BIAS_RELU_SER_RELU_EN).
module tb_bias_relu_serializer_cxy;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] d;
        int           idx;
    } wrd_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic signed [W-1:0] din [6];
    logic                b_wen, b_ren;
    logic [2:0]          b_addr;
    logic [W-1:0]        b_wdata;
    logic [W-1:0]        b_rdata;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [2:0]          out_idx;
    logic                out_last;
    logic                ovf;
    logic                ovf_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    wrd_t                expq[$];
    logic signed [W-1:0] m_bias [6];
    bit                  m_ovf;

    bias_relu_serializer_cxy dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN1       (din[0]),
        .IN2       (din[1]),
        .IN3       (din[2]),
        .IN4       (din[3]),
        .IN5       (din[4]),
        .IN6       (din[5]),
        .B_WEN     (b_wen),
        .B_REN     (b_ren),
        .B_ADDR    (b_addr),
        .B_WDATA   (b_wdata),
        .B_RDATA   (b_rdata),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_IDX   (out_idx),
        .OUT_LAST  (out_last),
        .OVF       (ovf),
        .OVF_CLR   (ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] exp_word(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
        longint s;
        s = longint'(a) + longint'(b);
        if (s > 8388607)  s = 8388607;
        if (s < -8388608) s = -8388608;
`ifdef BIAS_RELU_SER_RELU_EN
        if (s < 0) s = 0;
`endif
        return W'(s);
    endfunction

    task automatic push_vec();
        for (int k = 0; k < 6; k++) begin
            expq.push_back('{exp_word(din[k], m_bias[k]), k});
        end
    endtask

    task automatic rand_vec();
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 5))
                0:       din[k] = 24'sh7FFFFF;
                1:       din[k] = 24'sh800000;
                default: din[k] = W'($urandom);
            endcase
        end
    endtask

    task automatic wr_bias(input int a, input logic [W-1:0] v);
        @(negedge clk);
        b_wen   = 1'b1;
        b_addr  = a[2:0];
        b_wdata = v;
        if (a < 6) m_bias[a] = v;
        @(negedge clk);
        b_wen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 3'd0 ||
            out_last !== 1'b0 || ovf !== 1'b0 || b_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b d=%0h i=%0d l=%0b o=%0b r=%0h required all zero",
                     out_valid, out_data, out_idx, out_last, ovf, b_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_bias_rw();
        logic [W-1:0] exp;
        for (int i = 0; i < 6; i++) wr_bias(i, W'(i + 1));
        wr_bias(6, 24'h000055);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b_ren  = 1'b1;
            b_addr = 3'(i);
            exp    = (i < 6) ? W'(i + 1) : '0;
            @(negedge clk);
            b_ren  = 1'b0;
            b_addr = 3'((i + 3) % 8);
            n_cmp++;
            if (b_rdata !== exp) begin
                n_fail++;
                $display("FAIL bias_read[%0d]: got %0h required %0h", i, b_rdata, exp);
            end
            @(negedge clk);
            n_cmp++;
            if (b_rdata !== exp) begin
                n_fail++;
                $display("FAIL bias_hold[%0d]: got %0h required %0h", i, b_rdata, exp);
            end
        end
    endtask

    task automatic test_basic();
        int exp_v[6];
`ifdef BIAS_RELU_SER_RELU_EN
        exp_v = '{10, 0, 0, 7, 0, 3};
`else
        exp_v = '{10, -5, 0, 7, -1, 3};
`endif
        for (int i = 0; i < 6; i++) wr_bias(i, '0);
        @(negedge clk);
        din       = '{10, -5, 0, 7, -1, 3};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || int'($signed(out_data)) != exp_v[k] ||
                out_idx !== 3'(k) || out_last !== (k == 5)) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got v=%0b d=%0d i=%0d l=%0b required v=1 d=%0d i=%0d l=%0b",
                         k, out_valid, $signed(out_data), out_idx, out_last, exp_v[k], k, (k == 5));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got valid %0b required 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] exp [6];
        wr_bias(0, 24'h000100);
        wr_bias(1, 24'hFFFF00);
        for (int i = 2; i < 6; i++) wr_bias(i, W'($urandom_range(0, 1000)));
        @(negedge clk);
        din = '{24'sh7FFFF0, 24'sh800010, 1, -2, 3, -4};
        exp[0] = 24'h7FFFFF;
`ifdef BIAS_RELU_SER_RELU_EN
        exp[1] = 24'h000000;
`else
        exp[1] = 24'h800000;
`endif
        for (int k = 2; k < 6; k++) exp[k] = exp_word(din[k], m_bias[k]);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || out_idx !== 3'(k)) begin
                n_fail++;
                $display("FAIL sat_word[%0d]: got v=%0b d=%0h i=%0d required v=1 d=%0h i=%0d",
                         k, out_valid, out_data, out_idx, exp[k], k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) wr_bias(i, W'($urandom));
        @(negedge clk);
        out_ready = 1'b0;
        rand_vec();
        in_valid = 1'b1;
        push_vec();
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_after_1: got %0b required 0", ovf);
        end
        rand_vec();
        push_vec();
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_after_2: got %0b required 0", ovf);
        end
        rand_vec();
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got %0b required 1", ovf);
        end
        for (int h = 0; h < 2; h++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== expq[0].d || out_idx !== 3'd0 || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%0b d=%0h i=%0d l=%0b required v=1 d=%0h i=0 l=0",
                         h, out_valid, out_data, out_idx, out_last, expq[0].d);
            end
            if (h == 1) ovf_clr = 1'b1;
            @(negedge clk);
        end
        ovf_clr = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %0b required 0", ovf);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== expq[0].d || out_idx !== 3'(expq[0].idx) ||
                out_last !== (expq[0].idx == 5)) begin
                n_fail++;
                $display("FAIL ovf_drain[%0d]: got v=%0b d=%0h i=%0d l=%0b required v=1 d=%0h i=%0d",
                         i, out_valid, out_data, out_idx, out_last, expq[0].d, expq[0].idx);
            end
            void'(expq.pop_front());
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_drain_end: got valid %0b required 0", out_valid);
        end
    endtask

    task automatic test_coincident();
        @(negedge clk);
        out_ready = 1'b0;
        rand_vec();
        in_valid = 1'b1;
        push_vec();
        @(negedge clk);
        rand_vec();
        push_vec();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== expq[0].d || out_idx !== 3'(i)) begin
                n_fail++;
                $display("FAIL coin_first[%0d]: got v=%0b d=%0h i=%0d required v=1 d=%0h i=%0d",
                         i, out_valid, out_data, out_idx, expq[0].d, i);
            end
            void'(expq.pop_front());
            if (i == 5) begin
                rand_vec();
                in_valid = 1'b1;
                push_vec();
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL coin_no_ovf: got %0b required 0", ovf);
        end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== expq[0].d || out_idx !== 3'(expq[0].idx) ||
                out_last !== (expq[0].idx == 5)) begin
                n_fail++;
                $display("FAIL coin_drain[%0d]: got v=%0b d=%0h i=%0d l=%0b required v=1 d=%0h i=%0d",
                         i, out_valid, out_data, out_idx, out_last, expq[0].d, expq[0].idx);
            end
            void'(expq.pop_front());
            @(negedge clk);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL coin_end: got valid %0b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        bit mv, hs, lst, drop;
        int nvec;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        m_ovf = 1'b0;
        for (int k = 0; k < 6; k++) m_bias[k] = '0;
        for (int i = 0; i < 6; i++) wr_bias(i, ($urandom_range(0, 3) == 0) ? 24'h7FFFFF : W'($urandom));
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            mv = (expq.size() > 0);
            n_cmp++;
            if (out_valid !== mv) begin
                n_fail++;
                $display("FAIL rand_valid[%0d]: got %0b required %0b", c, out_valid, mv);
            end
            if (mv) begin
                n_cmp++;
                if (out_data !== expq[0].d || out_idx !== 3'(expq[0].idx) || out_last !== (expq[0].idx == 5)) begin
                    n_fail++;
                    $display("FAIL rand_word[%0d]: got d=%0h i=%0d l=%0b required d=%0h i=%0d",
                             c, out_data, out_idx, out_last, expq[0].d, expq[0].idx);
                end
            end
            n_cmp++;
            if (ovf !== m_ovf) begin
                n_fail++;
                $display("FAIL rand_ovf[%0d]: got %0b required %0b", c, ovf, m_ovf);
            end
            if (c < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 3) == 0);
                ovf_clr   = ($urandom_range(0, 15) == 0);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
                ovf_clr   = 1'b0;
            end
            if (in_valid) rand_vec();
            hs   = mv && out_ready;
            lst  = hs && (expq[0].idx == 5);
            nvec = (expq.size() + 5) / 6;
            if (hs) void'(expq.pop_front());
            drop = 1'b0;
            if (in_valid) begin
                if (nvec < 2 || lst) push_vec();
                else drop = 1'b1;
            end
            m_ovf = drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) wr_bias(i, W'($urandom) | 24'h000001);
        @(negedge clk);
        b_ren  = 1'b1;
        b_addr = 3'd0;
        @(negedge clk);
        b_ren = 1'b0;
        n_cmp++;
        if (b_rdata !== m_bias[0]) begin
            n_fail++;
            $display("FAIL mr_pre_read: got %0h required %0h", b_rdata, m_bias[0]);
        end
        out_ready = 1'b0;
        for (int v = 0; v < 3; v++) begin
            rand_vec();
            in_valid = 1'b1;
            if (v < 2) push_vec();
            @(negedge clk);
        end
        in_valid = 1'b0;
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_pre_ovf: got %0b required 1", ovf);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== expq[0].d || out_idx !== 3'(i)) begin
                n_fail++;
                $display("FAIL mr_word[%0d]: got v=%0b d=%0h i=%0d required v=1 d=%0h i=%0d",
                         i, out_valid, out_data, out_idx, expq[0].d, i);
            end
            void'(expq.pop_front());
            if (i == 3) rst = 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        expq.delete();
        m_ovf = 1'b0;
        for (int k = 0; k < 6; k++) m_bias[k] = '0;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 3'd0 ||
            out_last !== 1'b0 || ovf !== 1'b0 || b_rdata !== '0) begin
            n_fail++;
            $display("FAIL mr_reset_state: got v=%0b d=%0h i=%0d l=%0b o=%0b r=%0h required all zero",
                     out_valid, out_data, out_idx, out_last, ovf, b_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== '0) begin
                n_fail++;
                $display("FAIL mr_quiet[%0d]: got v=%0b d=%0h required v=0 d=0", i, out_valid, out_data);
            end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b_ren  = 1'b1;
            b_addr = 3'(i);
            @(negedge clk);
            b_ren = 1'b0;
            n_cmp++;
            if (b_rdata !== '0) begin
                n_fail++;
                $display("FAIL mr_bias_zero[%0d]: got %0h required 0", i, b_rdata);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        din       = '{0, 0, 0, 0, 0, 0};
        b_wen     = 1'b0;
        b_ren     = 1'b0;
        b_addr    = 3'd0;
        b_wdata   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        m_ovf     = 1'b0;
        for (int k = 0; k < 6; k++) m_bias[k] = '0;

        test_reset();
        test_bias_rw();
        test_basic();
        test_saturation();
        test_overflow();
        test_coincident();
        test_random();
        test_mid_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
